wb_retire_monitor: RTL and testbench
====================================

Name: wb_retire_monitor

Overview:
- Synthesizable retirement monitor at the writeback end of the 5-stage 16-bit pipeline.
- Consumes the per-cycle writeback retirement bundle: register write, store, load, halt and PC.
- Owns the architectural `hlt` output, the retired-instruction and cycle counters, and a small trace FIFO.
- The FIFO drains retirement records to a debug port through a valid/ready handshake.

Parameters:
- DATA_W, 16, datapath/PC/address width.
- REG_AW, 4, register index width.
- FIFO_DEPTH, 4, trace FIFO entries; power of two, ≥2.
- CNT_W, 32, width of inst/cycle counters.
- MAX_CYCLES, 100000, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- wb_valid  in  1  an instruction retires this cycle (bubbles/flushed slots = 0)
- wb_pc  in  DATA_W  PC of retiring instruction
- wb_regwrite  in  1  retiring instr writes register file
- wb_memread  in  1  retiring instr is a load
- wb_memwrite  in  1  retiring instr is a store
- wb_halt  in  1  retiring instr is HLT
- wb_dst_reg  in  REG_AW  destination register
- wb_dst_data  in  DATA_W  register write data
- wb_mem_addr  in  DATA_W  memory address (load/store)
- wb_mem_data  in  DATA_W  store data
- hlt  out  1  processor halted (sticky)
- inst_count  out  CNT_W  retired instructions
- cycle_count  out  CNT_W  cycles since reset release
- trace_valid  out  1  FIFO head valid
- trace_ready  in  1  consumer accepts head
- trace_kind  out  2  0=NOP/branch, 1=REG, 2=STORE, 3=HALT
- trace_load  out  1  REG record came from a load
- trace_pc  out  DATA_W  record PC
- trace_reg  out  REG_AW  record register (0 if not REG)
- trace_data  out  DATA_W  REG: write data; STORE: store data; else 0
- trace_addr  out  DATA_W  load/store address; else 0
- trace_ovf  out  1  sticky: a record was dropped

Behaviour:
- Reset (rst_n=0 at posedge clk) clears everything:
  - hlt=0, counters=0, FIFO empty, trace_valid=0, trace_ovf=0, state=RUN.
  - Reset mid-operation discards all FIFO contents immediately.
- FSM states: RUN, HALTED (plus TIMEOUT, only with the optional feature).
- RUN:
  - cycle_count increments every cycle, saturating at all-ones.
  - A retire (wb_valid=1) increments inst_count (saturating) and pushes one record.
  - wb_halt with wb_valid moves to HALTED; hlt=1 from the next cycle.
- Record kind priority: wb_halt > wb_regwrite > wb_memwrite > NOP. trace_load = wb_regwrite & wb_memread.
- HALTED:
  - Absorbing until reset.
  - wb_valid ignored; inst_count and cycle_count frozen.
  - FIFO continues to drain.
- Halt retire cycle: HLT is itself counted, so inst_count includes it.
- FIFO timing:
  - Outputs are registered from the head entry.
  - A pop occurs when trace_valid & trace_ready.
  - A push is visible at the head no earlier than the next cycle; no fall-through.
- FIFO boundary cases:
  - Full with no pop in the same cycle: the record is dropped, trace_ovf set (sticky), counters still update.
  - Full with a pop in the same cycle: the push is accepted.
  - Empty with a push: trace_valid=1 the next cycle.
  - Read/write pointers wrap modulo FIFO_DEPTH; use an extra pointer bit to distinguish full from empty.
- Payload fields stay stable while trace_valid=1 and trace_ready=0.

Optional Feature:
- Macro: WB_RETIRE_CYCLE_LIMIT_EN.
- Defined:
  - In RUN, when cycle_count reaches MAX_CYCLES, the FSM enters TIMEOUT.
  - TIMEOUT behaves like HALTED: hlt=1, counters frozen.
  - An extra output port `timeout` (1 bit, reset 0) is asserted, sticky.
  - A HALT record is pushed with trace_pc = 16'hFFFF.
- Not defined: no TIMEOUT state, no `timeout` port, MAX_CYCLES unused.

Decomposition:
- Package wb_retire_pkg:
  - trace_kind_e enum (KIND_NOP, KIND_REG, KIND_STORE, KIND_HALT).
  - retire_rec_t packed struct (kind, load, pc, reg, data, addr).
  - state_e enum.
- Sub-module: retire_fifo, a parameterized synchronous FIFO of retire_rec_t with push/pop/full/empty.
  - The top holds the FSM, counters, record builder and overflow flag.

Test Plan:
- Reset, then 3 cycles idle with trace_ready=1:
  - cycle_count=3, inst_count=0, trace_valid=0, hlt=0.
- Retire REG r3=16'h00A5 at pc 16'h0004:
  - Next cycle: trace_kind=1, trace_reg=3, trace_data=16'h00A5, trace_pc=16'h0004, inst_count=1.
- Load r2←mem[16'h0010]=16'h1234, then store mem[16'h0020]=16'hBEEF, with trace_ready=1:
  - Two records in order: (kind=1, load=1, addr=16'h0010, data=16'h1234), then (kind=2, addr=16'h0020, data=16'hBEEF).
- trace_ready=0, 6 consecutive retires with FIFO_DEPTH=4:
  - 4 records stored, trace_ovf=1, inst_count=6.
  - Raise trace_ready: exactly 4 records drain, in order.
- Retire HLT at pc 16'h0030, then drive 5 more retires:
  - hlt=1 the next cycle, inst_count frozen at 1, only a HALT record with pc 16'h0030 appears.
  - Assert rst_n=0: all outputs clear.
- With WB_RETIRE_CYCLE_LIMIT_EN and MAX_CYCLES=20, no HLT:
  - At cycle 20: timeout=1, hlt=1, HALT record with pc 16'hFFFF.

Source files
------------

// File: rtl/wb_retire_pkg.sv
// wb_retire_pkg: shared types for the writeback retirement monitor.
//   trace_kind_e : kind of a trace record (NOP/branch, REG, STORE, HALT)
//   retire_rec_t : one trace FIFO entry
//   state_e      : monitor FSM state (TIMEOUT exists only when
//                  WB_RETIRE_CYCLE_LIMIT_EN is defined)
//   make_rec     : builds a record from the writeback bundle
package wb_retire_pkg;

  localparam int REC_DATA_W = 16;
  localparam int REC_REG_AW = 4;

  typedef enum logic [1:0] {
    KIND_NOP   = 2'd0,
    KIND_REG   = 2'd1,
    KIND_STORE = 2'd2,
    KIND_HALT  = 2'd3
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e             kind;
    logic                    load;
    logic [REC_DATA_W-1:0]   pc;
    logic [REC_REG_AW-1:0]   reg_idx;
    logic [REC_DATA_W-1:0]   data;
    logic [REC_DATA_W-1:0]   addr;
  } retire_rec_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTED  = 2'd1
`ifdef WB_RETIRE_CYCLE_LIMIT_EN
    ,ST_TIMEOUT = 2'd2
`endif
  } state_e;

  // Kind priority is halt > register write > store > NOP. Fields that do
  // not belong to the chosen kind are zeroed so the debug port is clean.
  function automatic retire_rec_t make_rec(
    input logic                  halt,
    input logic                  regwrite,
    input logic                  memread,
    input logic                  memwrite,
    input logic [REC_DATA_W-1:0] pc,
    input logic [REC_REG_AW-1:0] dst_reg,
    input logic [REC_DATA_W-1:0] dst_data,
    input logic [REC_DATA_W-1:0] mem_addr,
    input logic [REC_DATA_W-1:0] mem_data
  );
    retire_rec_t r;
    r    = '0;
    r.pc = pc;
    if (halt) begin
      r.kind = KIND_HALT;
    end else if (regwrite) begin
      r.kind    = KIND_REG;
      r.load    = memread;
      r.reg_idx = dst_reg;
      r.data    = dst_data;
      r.addr    = memread ? mem_addr : '0;
    end else if (memwrite) begin
      r.kind = KIND_STORE;
      r.data = mem_data;
      r.addr = mem_addr;
    end else begin
      r.kind = KIND_NOP;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_retire_monitor_if.sv
// wb_retire_monitor_if: writeback retirement bundle plus trace debug port.
//   wb_*    : per-cycle retirement bundle from the writeback stage
//   trace_* : FIFO head record and its valid/ready handshake
// Handshake: a record transfers on a rising clk edge where trace_valid and
// trace_ready are both 1. While trace_valid=1 and trace_ready=0 the record
// payload is held stable; trace_valid never depends on trace_ready.
// Modports: master = pipeline/consumer side, slave = the monitor.
interface wb_retire_monitor_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic              wb_valid;
  logic [DATA_W-1:0] wb_pc;
  logic              wb_regwrite;
  logic              wb_memread;
  logic              wb_memwrite;
  logic              wb_halt;
  logic [REG_AW-1:0] wb_dst_reg;
  logic [DATA_W-1:0] wb_dst_data;
  logic [DATA_W-1:0] wb_mem_addr;
  logic [DATA_W-1:0] wb_mem_data;

  logic              trace_valid;
  logic              trace_ready;
  logic [1:0]        trace_kind;
  logic              trace_load;
  logic [DATA_W-1:0] trace_pc;
  logic [REG_AW-1:0] trace_reg;
  logic [DATA_W-1:0] trace_data;
  logic [DATA_W-1:0] trace_addr;

  modport master (
    output wb_valid, wb_pc, wb_regwrite, wb_memread, wb_memwrite, wb_halt,
           wb_dst_reg, wb_dst_data, wb_mem_addr, wb_mem_data, trace_ready,
    input  trace_valid, trace_kind, trace_load, trace_pc, trace_reg,
           trace_data, trace_addr
  );

  modport slave (
    input  wb_valid, wb_pc, wb_regwrite, wb_memread, wb_memwrite, wb_halt,
           wb_dst_reg, wb_dst_data, wb_mem_addr, wb_mem_data, trace_ready,
    output trace_valid, trace_kind, trace_load, trace_pc, trace_reg,
           trace_data, trace_addr
  );
endinterface

// File: rtl/retire_fifo.sv
// retire_fifo: synchronous FIFO of retire_rec_t records.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push, push_rec : write request and record; accepted if not full or
//                    if a pop happens in the same cycle
//   pop        : remove head (ignored when empty)
//   head       : current head entry (read from storage registers)
//   full, empty: occupancy flags
module retire_fifo
  import wb_retire_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  retire_rec_t push_rec,
  input  logic        pop,
  output retire_rec_t head,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);

  retire_rec_t mem [DEPTH];
  // Extra MSB on each pointer separates full (MSBs differ) from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        wr_en;
  logic        rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible once pointed to.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_rec;
  end
endmodule

// File: rtl/wb_retire_monitor.sv
// wb_retire_monitor: retirement monitor at the writeback end of the pipeline.
// Owns the sticky hlt output, saturating retired-instruction and cycle
// counters, and a trace FIFO draining records over a valid/ready port.
//   clk, rst_n  : clock, synchronous active-low reset
//   bus         : wb_retire_monitor_if.slave (wb_* bundle in, trace_* out)
//   hlt         : processor halted (sticky until reset)
//   inst_count  : retired instructions (HLT included)
//   cycle_count : cycles spent in RUN since reset release
//   trace_ovf   : sticky, a record was dropped on a full FIFO
//   timeout     : sticky cycle-limit hit (only with WB_RETIRE_CYCLE_LIMIT_EN)
//   dbg_state   : current FSM state
// Optional feature macro: WB_RETIRE_CYCLE_LIMIT_EN (cycle watchdog that
// forces a TIMEOUT state after MAX_CYCLES cycles in RUN).
module wb_retire_monitor
  import wb_retire_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_retire_monitor_if.slave   bus,
  output logic                 hlt,
  output logic [CNT_W-1:0]     inst_count,
  output logic [CNT_W-1:0]     cycle_count,
  output logic                 trace_ovf,
`ifdef WB_RETIRE_CYCLE_LIMIT_EN
  output logic                 timeout,
`endif
  output state_e               dbg_state
);
`ifndef WB_RETIRE_CYCLE_LIMIT_EN
  localparam int unused_max_cycles = MAX_CYCLES;
`endif

  state_e      state;
  state_e      state_next;
  logic        push_req;
  logic        count_inst;
  logic        count_cycle;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  retire_rec_t rec_in;
  retire_rec_t head;

  always_comb begin
    state_next  = state;
    push_req    = 1'b0;
    count_inst  = 1'b0;
    count_cycle = 1'b0;
    rec_in      = make_rec(bus.wb_halt, bus.wb_regwrite, bus.wb_memread,
                           bus.wb_memwrite, bus.wb_pc, bus.wb_dst_reg,
                           bus.wb_dst_data, bus.wb_mem_addr, bus.wb_mem_data);
    case (state)
      ST_RUN: begin
`ifdef WB_RETIRE_CYCLE_LIMIT_EN
        // The watchdog wins over a retire in the same cycle; that retire
        // is neither counted nor traced.
        if (cycle_count >= CNT_W'(MAX_CYCLES)) begin
          state_next  = ST_TIMEOUT;
          push_req    = 1'b1;
          rec_in      = '0;
          rec_in.kind = KIND_HALT;
          rec_in.pc   = '1;
        end else
`endif
        begin
          count_cycle = 1'b1;
          if (bus.wb_valid) begin
            push_req   = 1'b1;
            count_inst = 1'b1;
            if (bus.wb_halt) state_next = ST_HALTED;
          end
        end
      end
      default: ;  // halted states absorb until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      inst_count  <= '0;
      cycle_count <= '0;
      trace_ovf   <= 1'b0;
    end else begin
      state <= state_next;
      if (count_cycle && (cycle_count != '1)) cycle_count <= cycle_count + 1'b1;
      if (count_inst && (inst_count != '1))   inst_count  <= inst_count + 1'b1;
      if (push_req && fifo_full && !pop)      trace_ovf   <= 1'b1;
    end
  end

  assign pop = ~fifo_empty & bus.trace_ready;

  retire_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_req),
    .push_rec (rec_in),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Payload reads as zero when no record is present.
  assign bus.trace_valid = ~fifo_empty;
  assign bus.trace_kind  = fifo_empty ? 2'b00 : head.kind;
  assign bus.trace_load  = ~fifo_empty & head.load;
  assign bus.trace_pc    = fifo_empty ? '0 : DATA_W'(head.pc);
  assign bus.trace_reg   = fifo_empty ? '0 : REG_AW'(head.reg_idx);
  assign bus.trace_data  = fifo_empty ? '0 : DATA_W'(head.data);
  assign bus.trace_addr  = fifo_empty ? '0 : DATA_W'(head.addr);

  assign hlt       = (state != ST_RUN);
  assign dbg_state = state;
`ifdef WB_RETIRE_CYCLE_LIMIT_EN
  assign timeout   = (state == ST_TIMEOUT);
`endif
endmodule

// File: tb/tb_wb_retire_monitor.sv
// tb_wb_retire_monitor: directed bench for wb_retire_monitor with a record
// scoreboard; expected records are queued when retires are driven and
// compared when the trace port hands them out.
module tb_wb_retire_monitor;
  import wb_retire_pkg::*;

  localparam int W = 55;  // kind + load + pc + reg + data + addr

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_retire_monitor_if #(.DATA_W(16), .REG_AW(4)) bus ();

  logic        hlt;
  logic [31:0] inst_count;
  logic [31:0] cycle_count;
  logic        trace_ovf;
  state_e      dbg_state;
`ifdef WB_RETIRE_CYCLE_LIMIT_EN
  logic        timeout;
`endif

  wb_retire_monitor #(
    .DATA_W(16), .REG_AW(4), .FIFO_DEPTH(4), .CNT_W(32), .MAX_CYCLES(20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .hlt         (hlt),
    .inst_count  (inst_count),
    .cycle_count (cycle_count),
    .trace_ovf   (trace_ovf),
`ifdef WB_RETIRE_CYCLE_LIMIT_EN
    .timeout     (timeout),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_cnt(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_rec(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_rec(
    input logic [15:0] pc, input logic rw, input logic mr, input logic mw,
    input logic hl, input logic [3:0] dst, input logic [15:0] dd,
    input logic [15:0] ma, input logic [15:0] md);
    logic [1:0]  k;
    logic        ld;
    logic [3:0]  r;
    logic [15:0] d;
    logic [15:0] a;
    k = 2'd0; ld = 1'b0; r = 4'd0; d = 16'd0; a = 16'd0;
    if (hl) k = 2'd3;
    else if (rw) begin
      k = 2'd1; ld = mr; r = dst; d = dd; a = mr ? ma : 16'd0;
    end else if (mw) begin
      k = 2'd2; d = md; a = ma;
    end
    return {k, ld, pc, r, d, a};
  endfunction

  function automatic logic [W-1:0] obs_rec();
    return {bus.trace_kind, bus.trace_load, bus.trace_pc, bus.trace_reg,
            bus.trace_data, bus.trace_addr};
  endfunction

  // Consumer side, sampled on the falling edge: a handshake seen here
  // completes at the next rising edge unless reset is being applied.
  logic [W-1:0] held;
  logic         held_v = 1'b0;
  always @(negedge clk) begin
    if (held_v && bus.trace_valid) check_rec("stall_stable", obs_rec(), held);
    held_v = rst_n && bus.trace_valid && !bus.trace_ready;
    held   = obs_rec();
    if (rst_n && bus.trace_valid && bus.trace_ready) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL extra_record: observed %h expected no record", obs_rec());
      end
      if (exp_q.size() != 0) check_rec("record", obs_rec(), exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_wb();
    bus.wb_valid = 1'b0; bus.wb_pc = '0; bus.wb_regwrite = 1'b0;
    bus.wb_memread = 1'b0; bus.wb_memwrite = 1'b0; bus.wb_halt = 1'b0;
    bus.wb_dst_reg = '0; bus.wb_dst_data = '0; bus.wb_mem_addr = '0;
    bus.wb_mem_data = '0;
  endtask

  task automatic retire(input logic [15:0] pc, input logic rw, input logic mr,
                        input logic mw, input logic hl, input logic [3:0] dst,
                        input logic [15:0] dd, input logic [15:0] ma,
                        input logic [15:0] md, input bit expect_push);
    bus.wb_valid = 1'b1; bus.wb_pc = pc; bus.wb_regwrite = rw;
    bus.wb_memread = mr; bus.wb_memwrite = mw; bus.wb_halt = hl;
    bus.wb_dst_reg = dst; bus.wb_dst_data = dd; bus.wb_mem_addr = ma;
    bus.wb_mem_data = md;
    if (expect_push) exp_q.push_back(exp_rec(pc, rw, mr, mw, hl, dst, dd, ma, md));
    @(posedge clk); #1;
    clear_wb();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check_cnt(tag, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    clear_wb();
    bus.trace_ready = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle after reset
    repeat (3) begin @(posedge clk); #1; end
    check_cnt("idle_cycle_count", int'(cycle_count), 3);
    check_cnt("idle_inst_count", int'(inst_count), 0);
    check_cnt("idle_trace_valid", int'(bus.trace_valid), 0);
    check_cnt("idle_hlt", int'(hlt), 0);
    check_cnt("idle_ovf", int'(trace_ovf), 0);
    check_cnt("idle_state", int'(dbg_state), 0);

    // Single REG retire, visible the cycle after
    retire(16'h0004, 1, 0, 0, 0, 4'd3, 16'h00A5, 16'h0, 16'h0, 1);
    check_cnt("reg_valid", int'(bus.trace_valid), 1);
    check_cnt("reg_kind", int'(bus.trace_kind), 1);
    check_cnt("reg_reg", int'(bus.trace_reg), 3);
    check_cnt("reg_data", int'(bus.trace_data), 16'h00A5);
    check_cnt("reg_pc", int'(bus.trace_pc), 16'h0004);
    check_cnt("reg_inst_count", int'(inst_count), 1);
    drain("drain_reg");

    // Load then store back to back
    retire(16'h0008, 1, 1, 0, 0, 4'd2, 16'h1234, 16'h0010, 16'h0, 1);
    retire(16'h000C, 0, 0, 1, 0, 4'd0, 16'h0, 16'h0020, 16'hBEEF, 1);
    drain("drain_ld_st");
    check_cnt("ld_st_inst_count", int'(inst_count), 3);
    @(posedge clk); #1;
    check_cnt("ld_st_empty", int'(bus.trace_valid), 0);

    // Overflow: six retires into a 4-deep FIFO with no consumer
    bus.trace_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++)
      retire(16'h0100 + 16'(2 * i), 1, 0, 0, 0, 4'(i), 16'h1000 + 16'(i),
             16'h0, 16'h0, i < 4);
    check_cnt("ovf_flag", int'(trace_ovf), 1);
    check_cnt("ovf_inst_count", int'(inst_count), 6);
    check_cnt("ovf_valid", int'(bus.trace_valid), 1);
    bus.trace_ready = 1'b1;
    drain("drain_ovf");
    repeat (2) begin @(posedge clk); #1; end
    check_cnt("ovf_drained_valid", int'(bus.trace_valid), 0);
    check_cnt("ovf_sticky", int'(trace_ovf), 1);

    // Full FIFO with a pop in the same cycle accepts the push
    bus.trace_ready = 1'b0;
    do_reset();
    check_cnt("rst_ovf_clear", int'(trace_ovf), 0);
    for (int i = 0; i < 4; i++)
      retire(16'h0040 + 16'(i), 0, 0, 1, 0, 4'd0, 16'h0, 16'h0300 + 16'(i),
             16'hA000 + 16'(i), 1);
    bus.trace_ready = 1'b1;
    retire(16'h0050, 1, 0, 0, 0, 4'd7, 16'h7777, 16'h0, 16'h0, 1);
    bus.trace_ready = 1'b0;
    check_cnt("full_pop_ovf", int'(trace_ovf), 0);
    check_cnt("full_pop_inst", int'(inst_count), 5);
    check_cnt("full_pop_valid", int'(bus.trace_valid), 1);
    @(posedge clk); #1;
    // Reset with a full FIFO discards every pending record
    do_reset();
    check_cnt("rst_discard_valid", int'(bus.trace_valid), 0);
    check_cnt("rst_inst_count", int'(inst_count), 0);
    check_cnt("rst_cycle_count", int'(cycle_count), 0);
    bus.trace_ready = 1'b1;
    retire(16'h0200, 1, 1, 0, 0, 4'd9, 16'h5A5A, 16'h0044, 16'h0, 1);
    drain("drain_after_rst");

    // Halt: later retires ignored, counters frozen
    do_reset();
    retire(16'h0030, 0, 0, 0, 1, 4'd0, 16'h0, 16'h0, 16'h0, 1);
    check_cnt("halt_hlt", int'(hlt), 1);
    check_cnt("halt_inst_count", int'(inst_count), 1);
    check_cnt("halt_state", int'(dbg_state), 1);
    for (int i = 0; i < 5; i++)
      retire(16'h0034 + 16'(4 * i), 1, 0, 0, 0, 4'd1, 16'h00FF, 16'h0, 16'h0, 0);
    check_cnt("halt_inst_frozen", int'(inst_count), 1);
    check_cnt("halt_cycle_frozen", int'(cycle_count), 1);
    drain("drain_halt");
    repeat (2) begin @(posedge clk); #1; end
    check_cnt("halt_no_more_records", int'(bus.trace_valid), 0);
    check_cnt("halt_still_hlt", int'(hlt), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_cnt("final_rst_hlt", int'(hlt), 0);
    check_cnt("final_rst_inst", int'(inst_count), 0);
    check_cnt("final_rst_cycle", int'(cycle_count), 0);
    check_cnt("final_rst_valid", int'(bus.trace_valid), 0);
    check_cnt("final_rst_ovf", int'(trace_ovf), 0);
    rst_n = 1'b1;

`ifdef WB_RETIRE_CYCLE_LIMIT_EN
    // Cycle watchdog with MAX_CYCLES=20 and no halt
    do_reset();
    exp_q.push_back(exp_rec(16'hFFFF, 0, 0, 0, 1, 4'd0, 16'h0, 16'h0, 16'h0));
    for (int i = 0; i < 30 && !timeout; i++) begin @(posedge clk); #1; end
    check_cnt("to_timeout", int'(timeout), 1);
    check_cnt("to_hlt", int'(hlt), 1);
    check_cnt("to_cycle_count", int'(cycle_count), 20);
    drain("drain_timeout");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
